// File: rtl/interval_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer_if
// Description : Request/reprogram/status bundle between the traffic FSM side
//               and the interval timer.
// Revision    : 1.0
// ============================================================================
interface interval_timer_if;
    logic       one_hz_enable;
    logic       start_timer;
    logic [1:0] requesting_interval;
    logic       reprogram;
    logic [1:0] time_param_selector;
    logic [3:0] time_value;
    logic       expired;
    logic       busy;
    logic [3:0] count_remaining;

    modport master (
        output one_hz_enable,
        output start_timer,
        output requesting_interval,
        output reprogram,
        output time_param_selector,
        output time_value,
        input  expired,
        input  busy,
        input  count_remaining
    );

    modport slave (
        input  one_hz_enable,
        input  start_timer,
        input  requesting_interval,
        input  reprogram,
        input  time_param_selector,
        input  time_value,
        output expired,
        output busy,
        output count_remaining
    );
endinterface
`default_nettype wire

// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer
// Description : Programmable one-second interval timer with three
//               reprogrammable intervals and a single-cycle expired pulse.
// Revision    : 1.0
// ============================================================================
module interval_timer #(
    parameter logic [3:0] T_BASE_DEF = 4'd6,
    parameter logic [3:0] T_EXT_DEF  = 4'd3,
    parameter logic [3:0] T_YEL_DEF  = 4'd2
) (
    input  wire              clk,
    input  wire              reset,
    interval_timer_if.slave  tmr
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    localparam logic [1:0] c_SEL_BASE = 2'b00;
    localparam logic [1:0] c_SEL_EXT  = 2'b01;
    localparam logic [1:0] c_SEL_YEL  = 2'b10;

    state_t     r_state;
    logic [3:0] r_t_base;
    logic [3:0] r_t_ext;
    logic [3:0] r_t_yel;
    logic [3:0] r_count;
    logic       r_expired;
    logic       r_busy;
    logic [3:0] w_load_value;

    // Interval code 11 falls back to the base interval.
    always_comb begin
        w_load_value = r_t_base;
        case (tmr.requesting_interval)
            c_SEL_EXT: w_load_value = r_t_ext;
            c_SEL_YEL: w_load_value = r_t_yel;
            default:   w_load_value = r_t_base;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_t_base  <= T_BASE_DEF;
            r_t_ext   <= T_EXT_DEF;
            r_t_yel   <= T_YEL_DEF;
            r_state   <= ST_IDLE;
            r_count   <= 4'd0;
            r_expired <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (tmr.reprogram) begin
                // A zero value is never stored, but the abort still happens.
                if (tmr.time_value != 4'd0) begin
                    case (tmr.time_param_selector)
                        c_SEL_BASE: r_t_base <= tmr.time_value;
                        c_SEL_EXT:  r_t_ext  <= tmr.time_value;
                        c_SEL_YEL:  r_t_yel  <= tmr.time_value;
                        default:    ;
                    endcase
                end
                r_state <= ST_IDLE;
                r_count <= 4'd0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (tmr.start_timer) begin
                            r_count <= w_load_value;
                            r_state <= ST_COUNT;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_COUNT: begin
                        if (tmr.start_timer) begin
                            r_count <= w_load_value;
                        end else if (tmr.one_hz_enable) begin
                            if (r_count > 4'd1) begin
                                r_count <= r_count - 4'd1;
                            end else begin
                                r_count   <= 4'd0;
                                r_state   <= ST_IDLE;
                                r_busy    <= 1'b0;
                                r_expired <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_count <= 4'd0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tmr.expired         = r_expired;
    assign tmr.busy            = r_busy;
    assign tmr.count_remaining = r_count;

endmodule
`default_nettype wire

// File: tb/tb_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_interval_timer
// Description : Directed self-checking bench for interval_timer.
// Revision    : 1.0
// ============================================================================
module tb_interval_timer;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    interval_timer_if bus ();

    interval_timer #(
        .T_BASE_DEF(4'd6),
        .T_EXT_DEF (4'd3),
        .T_YEL_DEF (4'd2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .tmr  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs; returns at the falling edge after the
    // rising edge that sampled them, so outputs reflect that edge.
    task automatic cyc(input logic r, input logic tk, input logic st,
                       input logic [1:0] ri, input logic rp,
                       input logic [1:0] sel, input logic [3:0] v);
        reset                   = r;
        bus.one_hz_enable       = tk;
        bus.start_timer         = st;
        bus.requesting_interval = ri;
        bus.reprogram           = rp;
        bus.time_param_selector = sel;
        bus.time_value          = v;
        @(negedge clk);
    endtask

    // Output word compared below is {expired, busy, count_remaining}.
    task automatic test_reset;
        cyc(1, 0, 0, 2'b00, 0, 2'b00, 4'd0);
        cyc(1, 1, 1, 2'b00, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_state: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b000000);
        end
        cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b000000) begin
            n_err++;
            $display("FAIL idle_ignores_tick: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b000000);
        end
    endtask

    task automatic test_base_count;
        logic [5:0] exp;
        cyc(0, 0, 1, 2'b00, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b010110) begin
            n_err++;
            $display("FAIL base_load: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b010110);
        end
        for (int k = 1; k <= 6; k++) begin
            for (int g = 0; g < 9; g++) begin
                cyc(0, 0, 0, 2'b00, 0, 2'b00, 4'd0);
                exp = {1'b0, 1'b1, 4'(7 - k)};
                n_vec++;
                if ({bus.expired, bus.busy, bus.count_remaining} !== exp) begin
                    n_err++;
                    $display("FAIL base_hold tick%0d: got %b exp %b", k,
                             {bus.expired, bus.busy, bus.count_remaining}, exp);
                end
            end
            cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
            exp = (k < 6) ? {1'b0, 1'b1, 4'(6 - k)} : 6'b100000;
            n_vec++;
            if ({bus.expired, bus.busy, bus.count_remaining} !== exp) begin
                n_err++;
                $display("FAIL base_tick%0d: got %b exp %b", k,
                         {bus.expired, bus.busy, bus.count_remaining}, exp);
            end
        end
        cyc(0, 0, 0, 2'b00, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b000000) begin
            n_err++;
            $display("FAIL base_expired_width: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b000000);
        end
    endtask

    task automatic test_reprogram_yel;
        logic [5:0] exp;
        for (int pass = 0; pass < 2; pass++) begin
            // Second pass writes zero, which must leave t_yel at 5.
            cyc(0, 0, 0, 2'b00, 1, 2'b10, (pass == 0) ? 4'd5 : 4'd0);
            n_vec++;
            if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b000000) begin
                n_err++;
                $display("FAIL yel_write pass%0d: got %b exp %b", pass,
                         {bus.expired, bus.busy, bus.count_remaining}, 6'b000000);
            end
            cyc(0, 0, 1, 2'b10, 0, 2'b00, 4'd0);
            for (int k = 0; k <= 5; k++) begin
                if (k > 0) begin
                    cyc(0, 0, 0, 2'b00, 0, 2'b00, 4'd0);
                    cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
                end
                exp = (k < 5) ? {1'b0, 1'b1, 4'(5 - k)} : 6'b100000;
                n_vec++;
                if ({bus.expired, bus.busy, bus.count_remaining} !== exp) begin
                    n_err++;
                    $display("FAIL yel_count pass%0d step%0d: got %b exp %b", pass, k,
                             {bus.expired, bus.busy, bus.count_remaining}, exp);
                end
            end
        end
    endtask

    task automatic test_restart;
        logic [5:0] exp;
        cyc(0, 0, 1, 2'b01, 0, 2'b00, 4'd0);
        cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
        cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b010001) begin
            n_err++;
            $display("FAIL ext_two_ticks: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b010001);
        end
        cyc(0, 0, 1, 2'b10, 0, 2'b00, 4'd0);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
            exp = (k < 5) ? {1'b0, 1'b1, 4'(5 - k)} : 6'b100000;
            n_vec++;
            if ({bus.expired, bus.busy, bus.count_remaining} !== exp) begin
                n_err++;
                $display("FAIL restart_count step%0d: got %b exp %b", k,
                         {bus.expired, bus.busy, bus.count_remaining}, exp);
            end
        end
    endtask

    task automatic test_start_with_tick;
        logic [5:0] exp;
        cyc(0, 1, 1, 2'b00, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b010110) begin
            n_err++;
            $display("FAIL start_tick_load: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b010110);
        end
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b010001) begin
            n_err++;
            $display("FAIL start_tick_at_one: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b010001);
        end
        // Restart coincident with what would have been the final tick.
        cyc(0, 1, 1, 2'b01, 0, 2'b00, 4'd0);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
            exp = (k < 3) ? {1'b0, 1'b1, 4'(3 - k)} : 6'b100000;
            n_vec++;
            if ({bus.expired, bus.busy, bus.count_remaining} !== exp) begin
                n_err++;
                $display("FAIL final_tick_restart step%0d: got %b exp %b", k,
                         {bus.expired, bus.busy, bus.count_remaining}, exp);
            end
        end
    endtask

    task automatic test_reprogram_abort;
        logic [5:0] exp;
        cyc(0, 0, 1, 2'b00, 0, 2'b00, 4'd0);
        cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
        cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
        cyc(0, 1, 1, 2'b01, 1, 2'b00, 4'd9);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b000000) begin
            n_err++;
            $display("FAIL abort_midcount: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b000000);
        end
        cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b000000) begin
            n_err++;
            $display("FAIL abort_stays_idle: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b000000);
        end
        cyc(0, 0, 1, 2'b00, 0, 2'b00, 4'd0);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) begin
                cyc(0, 0, 0, 2'b00, 0, 2'b00, 4'd0);
                cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
            end
            exp = (k < 9) ? {1'b0, 1'b1, 4'(9 - k)} : 6'b100000;
            n_vec++;
            if ({bus.expired, bus.busy, bus.count_remaining} !== exp) begin
                n_err++;
                $display("FAIL base9_count step%0d: got %b exp %b", k,
                         {bus.expired, bus.busy, bus.count_remaining}, exp);
            end
        end
        // Selector 11 and zero-value writes abort without changing registers.
        cyc(0, 0, 1, 2'b11, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b011001) begin
            n_err++;
            $display("FAIL interval11_is_base: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b011001);
        end
        cyc(0, 0, 0, 2'b00, 1, 2'b11, 4'd7);
        cyc(0, 0, 1, 2'b00, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b011001) begin
            n_err++;
            $display("FAIL sel11_no_write: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b011001);
        end
        cyc(0, 0, 0, 2'b00, 1, 2'b01, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b000000) begin
            n_err++;
            $display("FAIL zero_write_aborts: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b000000);
        end
        cyc(0, 0, 1, 2'b01, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b010011) begin
            n_err++;
            $display("FAIL ext_unchanged: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b010011);
        end
    endtask

    task automatic test_reset_midcount;
        logic [5:0] exp;
        cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b010010) begin
            n_err++;
            $display("FAIL pre_reset_count: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b010010);
        end
        cyc(1, 1, 0, 2'b00, 1, 2'b00, 4'd5);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_midcount: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b000000);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
            n_vec++;
            if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b000000) begin
                n_err++;
                $display("FAIL post_reset_quiet%0d: got %b exp %b", k,
                         {bus.expired, bus.busy, bus.count_remaining}, 6'b000000);
            end
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 2'(k), 0, 2'b00, 4'd0);
            exp = (k == 0) ? 6'b010110 : (k == 1) ? 6'b010011 : 6'b010010;
            n_vec++;
            if ({bus.expired, bus.busy, bus.count_remaining} !== exp) begin
                n_err++;
                $display("FAIL default_reg%0d: got %b exp %b", k,
                         {bus.expired, bus.busy, bus.count_remaining}, exp);
            end
        end
        cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
        cyc(0, 1, 0, 2'b00, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b100000) begin
            n_err++;
            $display("FAIL yel_default_expire: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b100000);
        end
        cyc(0, 0, 0, 2'b00, 0, 2'b00, 4'd0);
        n_vec++;
        if ({bus.expired, bus.busy, bus.count_remaining} !== 6'b000000) begin
            n_err++;
            $display("FAIL final_idle: got %b exp %b",
                     {bus.expired, bus.busy, bus.count_remaining}, 6'b000000);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_base_count();
        test_reprogram_yel();
        test_restart();
        test_start_with_tick();
        test_reprogram_abort();
        test_reset_midcount();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
